// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the streaming NN pipeline blocks:
//   - BIAS_W / SHIFT_W : width of each per-channel bias and right-shift field
//   - SAT_W            : working width accepted by sat_signed()
//   - acc_width()      : pointwise accumulator width for N-bit data and IC inputs
//   - sat_signed()     : clamp a wide signed value into the N-bit signed range
//   - walk_state_t     : state encoding of the padded-grid walker
// ---------------------------------------------------------------------------
package nn_pkg;

    localparam int BIAS_W  = 32;
    localparam int SHIFT_W = 5;
    localparam int SAT_W   = 64;

    typedef enum logic {
        WALK_IDLE = 1'b0,
        WALK_RUN  = 1'b1
    } walk_state_t;

    // Room for IC full-width products plus one sign/carry bit, never below 32
    // so a 32-bit bias always fits.
    function automatic int acc_width(input int n, input int ic);
        int w;
        w = 2 * n + $clog2(ic) + 1;
        return (w > 32) ? w : 32;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int                      n
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/pad_stride_walker.sv
// ---------------------------------------------------------------------------
// pad_stride_walker
// Walks the zero-padded (INPUT_SIZE+2*PADDING)^2 grid in raster order and
// decides, per position, whether a pixel enters the datapath.
//   clk, rst_n  : clock, asynchronous active-low reset
//   input_vld   : upstream pixel valid
//   input_rdy   : high on real (non-pad) positions while running
//   pix_take    : current position advances and is on-stride -> datapath load
//   pix_pad     : current position is a pad position (inject zero pixel)
//   pix_end     : pix_take for the last on-stride position of the frame
// ---------------------------------------------------------------------------
module pad_stride_walker
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE  = 6,
    parameter int STRIDE      = 1,
    parameter int PADDING     = 0,
    parameter int OUTPUT_SIZE = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic input_vld,
    output logic input_rdy,
    output logic pix_take,
    output logic pix_pad,
    output logic pix_end
);

    localparam int PAD_SIZE = INPUT_SIZE + 2 * PADDING;
    localparam int CNT_W    = $clog2(PAD_SIZE + 1);
    localparam int PH_W     = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CNT_W-1:0] LAST_POS    = CNT_W'(PAD_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_ON     = CNT_W'((OUTPUT_SIZE - 1) * STRIDE);
    localparam logic [PH_W-1:0]  STRIDE_LAST = PH_W'(STRIDE - 1);

    walk_state_t      state, state_nxt;
    logic [CNT_W-1:0] row, row_nxt;
    logic [CNT_W-1:0] col, col_nxt;
    // Stride phases track r%STRIDE and c%STRIDE without a divider.
    logic [PH_W-1:0]  rph, rph_nxt;
    logic [PH_W-1:0]  cph, cph_nxt;

    logic row_pad, col_pad, is_pad, on_stride;

    if (PADDING > 0) begin : g_pad
        localparam logic [CNT_W-1:0] PAD_LO = CNT_W'(PADDING);
        localparam logic [CNT_W-1:0] PAD_HI = CNT_W'(PADDING + INPUT_SIZE);
        assign row_pad = (row < PAD_LO) || (row >= PAD_HI);
        assign col_pad = (col < PAD_LO) || (col >= PAD_HI);
    end else begin : g_nopad
        assign row_pad = 1'b0;
        assign col_pad = 1'b0;
    end

    assign is_pad    = row_pad || col_pad;
    assign on_stride = (rph == '0) && (cph == '0);
    assign pix_pad   = is_pad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WALK_IDLE;
            row   <= '0;
            col   <= '0;
            rph   <= '0;
            cph   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            rph   <= rph_nxt;
            cph   <= cph_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        rph_nxt   = rph;
        cph_nxt   = cph;
        input_rdy = 1'b0;
        pix_take  = 1'b0;
        pix_end   = 1'b0;
        case (state)
            WALK_IDLE: begin
                if (input_vld) begin
                    state_nxt = WALK_RUN;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    rph_nxt   = '0;
                    cph_nxt   = '0;
                end
            end
            WALK_RUN: begin
                input_rdy = ~is_pad;
                // Pad positions self-advance; real ones wait for the handshake.
                if (is_pad || input_vld) begin
                    pix_take = on_stride;
                    pix_end  = on_stride && (row == LAST_ON) && (col == LAST_ON);
                    if (col == LAST_POS) begin
                        col_nxt = '0;
                        cph_nxt = '0;
                        if (row == LAST_POS) begin
                            state_nxt = WALK_IDLE;
                            row_nxt   = '0;
                            rph_nxt   = '0;
                        end else begin
                            row_nxt = row + 1'b1;
                            rph_nxt = (rph == STRIDE_LAST) ? '0 : rph + 1'b1;
                        end
                    end else begin
                        col_nxt = col + 1'b1;
                        cph_nxt = (cph == STRIDE_LAST) ? '0 : cph + 1'b1;
                    end
                end
            end
            default: state_nxt = WALK_IDLE;
        endcase
    end

endmodule

// File: rtl/dwconv_k1s.sv
// ---------------------------------------------------------------------------
// dwconv_k1s
// Depthwise-separable 1x1 convolution with zero padding and stride.
// One pixel (all input channels) per handshake, raster order; emits
// OUTPUT_SIZE^2 output pixels per frame, three register stages deep.
//   clk, rst_n        : clock, asynchronous active-low reset
//   input_vld/rdy/din : input pixel handshake, channel i at [i*N +: N]
//   dconv_weight_din  : depthwise weight per input channel
//   pconv_weight_din  : pointwise weight (o,i) at index o*INPUT_CHANNEL+i
//   dconv_bias_din    : 32-bit signed bias per input channel
//   pconv_bias_din    : 32-bit signed bias per output channel
//   dconv_shift_din   : 5-bit arithmetic right shift per input channel
//   pconv_shift_din   : 5-bit arithmetic right shift per output channel
//   conv_dout         : output pixel, channel o at [o*N +: N]
//   conv_dout_vld     : output valid (no backpressure)
//   conv_dout_end     : marks the last output pixel of a frame
// Build option: define DWCONV_K1S_RELU_EN to clamp negatives to zero after
// both the depthwise and pointwise saturation.
// ---------------------------------------------------------------------------
module dwconv_k1s
    import nn_pkg::*;
#(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int INPUT_SIZE     = 6,
    parameter int OUTPUT_CHANNEL = 3,
    parameter int STRIDE         = 1,
    parameter int PADDING        = 0
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     input_vld,
    output logic                                     input_rdy,
    input  logic [INPUT_CHANNEL*N-1:0]               input_din,
    input  logic [INPUT_CHANNEL*N-1:0]               dconv_weight_din,
    input  logic [INPUT_CHANNEL*OUTPUT_CHANNEL*N-1:0] pconv_weight_din,
    input  logic [INPUT_CHANNEL*BIAS_W-1:0]          dconv_bias_din,
    input  logic [OUTPUT_CHANNEL*BIAS_W-1:0]         pconv_bias_din,
    input  logic [INPUT_CHANNEL*SHIFT_W-1:0]         dconv_shift_din,
    input  logic [OUTPUT_CHANNEL*SHIFT_W-1:0]        pconv_shift_din,
    output logic [OUTPUT_CHANNEL*N-1:0]              conv_dout,
    output logic                                     conv_dout_vld,
    output logic                                     conv_dout_end
);

    localparam int OUTPUT_SIZE = (INPUT_SIZE + 2 * PADDING - 1) / STRIDE + 1;
    localparam int PROD_W      = 2 * N;
    localparam int DW_W        = (PROD_W > BIAS_W) ? PROD_W : BIAS_W;
    localparam int ACC_W       = acc_width(N, INPUT_CHANNEL);

    function automatic logic signed [N-1:0] relu(input logic signed [N-1:0] v);
`ifdef DWCONV_K1S_RELU_EN
        return v[N-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    logic pix_take, pix_pad, pix_end;

    pad_stride_walker #(
        .INPUT_SIZE  (INPUT_SIZE),
        .STRIDE      (STRIDE),
        .PADDING     (PADDING),
        .OUTPUT_SIZE (OUTPUT_SIZE)
    ) u_walker (
        .clk       (clk),
        .rst_n     (rst_n),
        .input_vld (input_vld),
        .input_rdy (input_rdy),
        .pix_take  (pix_take),
        .pix_pad   (pix_pad),
        .pix_end   (pix_end)
    );

    // ---- stage p0: depthwise scale, bias, shift, saturate ----
    logic signed [N-1:0]      dw_x    [INPUT_CHANNEL];
    logic signed [N-1:0]      dw_w    [INPUT_CHANNEL];
    logic signed [PROD_W-1:0] dw_prod [INPUT_CHANNEL];
    logic signed [DW_W-1:0]   dw_sum  [INPUT_CHANNEL];
    logic signed [N-1:0]      y_nxt   [INPUT_CHANNEL];
    logic signed [N-1:0]      y_p0    [INPUT_CHANNEL];
    logic                     vld_p0, end_p0;

    always_comb begin
        for (int i = 0; i < INPUT_CHANNEL; i++) begin
            dw_x[i]    = pix_pad ? '0 : $signed(input_din[i*N +: N]);
            dw_w[i]    = $signed(dconv_weight_din[i*N +: N]);
            dw_prod[i] = PROD_W'(dw_x[i]) * PROD_W'(dw_w[i]);
            dw_sum[i]  = DW_W'(dw_prod[i])
                       + DW_W'($signed(dconv_bias_din[i*BIAS_W +: BIAS_W]));
            y_nxt[i]   = relu(N'(sat_signed(
                             SAT_W'(dw_sum[i] >>> dconv_shift_din[i*SHIFT_W +: SHIFT_W]), N)));
        end
    end

    always_ff @(posedge clk) begin
        if (pix_take) begin
            for (int i = 0; i < INPUT_CHANNEL; i++)
                y_p0[i] <= y_nxt[i];
        end
    end

    // ---- stage p1: pointwise products ----
    logic signed [N-1:0]      pw_w     [OUTPUT_CHANNEL][INPUT_CHANNEL];
    logic signed [PROD_W-1:0] prod_nxt [OUTPUT_CHANNEL][INPUT_CHANNEL];
    logic signed [PROD_W-1:0] prod_p1  [OUTPUT_CHANNEL][INPUT_CHANNEL];
    logic                     vld_p1, end_p1;

    always_comb begin
        for (int o = 0; o < OUTPUT_CHANNEL; o++) begin
            for (int i = 0; i < INPUT_CHANNEL; i++) begin
                pw_w[o][i]     = $signed(pconv_weight_din[(o*INPUT_CHANNEL+i)*N +: N]);
                prod_nxt[o][i] = PROD_W'(y_p0[i]) * PROD_W'(pw_w[o][i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int o = 0; o < OUTPUT_CHANNEL; o++)
                for (int i = 0; i < INPUT_CHANNEL; i++)
                    prod_p1[o][i] <= prod_nxt[o][i];
        end
    end

    // ---- stage p2: channel sum, bias, shift, saturate ----
    logic signed [ACC_W-1:0]     pw_acc [OUTPUT_CHANNEL];
    logic [OUTPUT_CHANNEL*N-1:0] z_nxt;

    always_comb begin
        z_nxt = '0;
        for (int o = 0; o < OUTPUT_CHANNEL; o++) begin
            pw_acc[o] = ACC_W'($signed(pconv_bias_din[o*BIAS_W +: BIAS_W]));
            for (int i = 0; i < INPUT_CHANNEL; i++)
                pw_acc[o] = pw_acc[o] + ACC_W'(prod_p1[o][i]);
            z_nxt[o*N +: N] = relu(N'(sat_signed(
                                  SAT_W'(pw_acc[o] >>> pconv_shift_din[o*SHIFT_W +: SHIFT_W]), N)));
        end
    end

    // Valids and the visible output are cleared by reset so an aborted
    // frame cannot leak a stale pixel after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0        <= 1'b0;
            end_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            end_p1        <= 1'b0;
            conv_dout     <= '0;
            conv_dout_vld <= 1'b0;
            conv_dout_end <= 1'b0;
        end else begin
            vld_p0        <= pix_take;
            end_p0        <= pix_end;
            vld_p1        <= vld_p0;
            end_p1        <= end_p0 & vld_p0;
            conv_dout_vld <= vld_p1;
            conv_dout_end <= end_p1 & vld_p1;
            if (vld_p1)
                conv_dout <= z_nxt;
        end
    end

endmodule

// File: tb/tb_dwconv_k1s.sv
module tb_dwconv_k1s;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared weight set, static during each frame.
    int dw [2];
    int db [2];
    int ds [2];
    int pw [4];
    int pb [2];
    int ps [2];

    logic [31:0] dwv;
    logic [63:0] pwv;
    logic [63:0] dbv;
    logic [63:0] pbv;
    logic [9:0]  dsv;
    logic [9:0]  psv;

    assign dwv = {dw[1][15:0], dw[0][15:0]};
    assign pwv = {pw[3][15:0], pw[2][15:0], pw[1][15:0], pw[0][15:0]};
    assign dbv = {db[1], db[0]};
    assign pbv = {pb[1], pb[0]};
    assign dsv = {ds[1][4:0], ds[0][4:0]};
    assign psv = {ps[1][4:0], ps[0][4:0]};

    logic [2:0]  ivld;
    logic [31:0] idin [3];
    logic        rdy0, rdy1, rdy2;
    logic [2:0]  irdy;
    logic [31:0] dout0, dout1, dout2;
    logic        dv0, dv1, dv2;
    logic        de0, de1, de2;

    assign irdy = {rdy2, rdy1, rdy0};

    // dut0: P=0 S=1, dut1: P=1 S=1, dut2: P=0 S=2
    dwconv_k1s #(.N(16), .INPUT_CHANNEL(2), .INPUT_SIZE(4), .OUTPUT_CHANNEL(2),
                 .STRIDE(1), .PADDING(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .input_vld(ivld[0]), .input_rdy(rdy0),
        .input_din(idin[0]), .dconv_weight_din(dwv), .pconv_weight_din(pwv),
        .dconv_bias_din(dbv), .pconv_bias_din(pbv), .dconv_shift_din(dsv),
        .pconv_shift_din(psv), .conv_dout(dout0), .conv_dout_vld(dv0),
        .conv_dout_end(de0));

    dwconv_k1s #(.N(16), .INPUT_CHANNEL(2), .INPUT_SIZE(4), .OUTPUT_CHANNEL(2),
                 .STRIDE(1), .PADDING(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .input_vld(ivld[1]), .input_rdy(rdy1),
        .input_din(idin[1]), .dconv_weight_din(dwv), .pconv_weight_din(pwv),
        .dconv_bias_din(dbv), .pconv_bias_din(pbv), .dconv_shift_din(dsv),
        .pconv_shift_din(psv), .conv_dout(dout1), .conv_dout_vld(dv1),
        .conv_dout_end(de1));

    dwconv_k1s #(.N(16), .INPUT_CHANNEL(2), .INPUT_SIZE(4), .OUTPUT_CHANNEL(2),
                 .STRIDE(2), .PADDING(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .input_vld(ivld[2]), .input_rdy(rdy2),
        .input_din(idin[2]), .dconv_weight_din(dwv), .pconv_weight_din(pwv),
        .dconv_bias_din(dbv), .pconv_bias_din(pbv), .dconv_shift_din(dsv),
        .pconv_shift_din(psv), .conv_dout(dout2), .conv_dout_vld(dv2),
        .conv_dout_end(de2));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Output capture, sampled on the falling edge.
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    int ncyc       = 0;
    int first_out0 = -1;
    int first_acc0 = -1;
    int acc_cnt [3] = '{0, 0, 0};

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (dv0) begin
            q0.push_back({de0, dout0});
            if (first_out0 < 0) first_out0 = ncyc;
        end
        if (dv1) q1.push_back({de1, dout1});
        if (dv2) q2.push_back({de2, dout2});
        if (ivld[0] && rdy0) begin
            acc_cnt[0] = acc_cnt[0] + 1;
            if (first_acc0 < 0) first_acc0 = ncyc;
        end
        if (ivld[1] && rdy1) acc_cnt[1] = acc_cnt[1] + 1;
        if (ivld[2] && rdy2) acc_cnt[2] = acc_cnt[2] + 1;
    end

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [32:0] q_get(input int d, input int i);
        case (d)
            0:       return q0[i];
            1:       return q1[i];
            default: return q2[i];
        endcase
    endfunction

    // Stimulus pixels and expected outputs.
    int px0 [16];
    int px1 [16];
    logic [31:0] expq[$];

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint relu_m(input longint v);
`ifdef DWCONV_K1S_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [31:0] model_px(input int x0, input int x1);
        longint     y [2];
        longint     z;
        int         xs [2];
        logic [31:0] r;
        r = '0;
        xs[0] = x0;
        xs[1] = x1;
        for (int i = 0; i < 2; i++)
            y[i] = relu_m(sat16((longint'(xs[i]) * dw[i] + db[i]) >>> ds[i]));
        for (int o = 0; o < 2; o++) begin
            z = pb[o];
            for (int i = 0; i < 2; i++)
                z = z + y[i] * pw[o*2+i];
            z = relu_m(sat16(z >>> ps[o]));
            r[o*16 +: 16] = z[15:0];
        end
        return r;
    endfunction

    task automatic set_identity();
        dw = '{1, 1}; db = '{0, 0}; ds = '{0, 0};
        pw = '{1, 0, 0, 1}; pb = '{0, 0}; ps = '{0, 0};
    endtask

    task automatic set_ramp();
        for (int p = 0; p < 16; p++) begin
            px0[p] = p + 1;
            px1[p] = 256 + p + 1;
        end
    endtask

    task automatic send_frame(input int d, input bit gapped, input int npix, output int wait0);
        int to;
        wait0 = 0;
        for (int p = 0; p < npix; p++) begin
            if (gapped) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    ivld[d] = 1'b0;
                    @(posedge clk); #1;
                end
            end
            ivld[d] = 1'b1;
            idin[d] = {px1[p][15:0], px0[p][15:0]};
            to = 0;
            forever begin
                @(negedge clk);
                if (irdy[d]) break;
                to++;
                if (p == 0) wait0++;
                if (to > 100) break;
            end
            if (to > 100) begin
                check_eq($sformatf("accept_timeout_d%0d_p%0d", d, p), 64'd0, 64'd1);
                ivld[d] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        ivld[d] = 1'b0;
    endtask

    task automatic check_out(input int d, input int base, input string tag);
        int          got_n;
        logic [32:0] e;
        got_n = q_size(d) - base;
        check_eq({tag, "_count"}, 64'(got_n), 64'(expq.size()));
        for (int j = 0; j < expq.size(); j++) begin
            if (j < got_n) begin
                e = q_get(d, base + j);
                check_eq($sformatf("%s_px%0d", tag, j), 64'(e[31:0]), 64'(expq[j]));
                check_eq($sformatf("%s_end%0d", tag, j), 64'(e[32]), 64'(j == expq.size() - 1));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int w;
        int acc0;
        logic [15:0] e0, e1;

        rst_n = 1'b0;
        ivld  = '0;
        for (int d = 0; d < 3; d++) idin[d] = '0;
        set_identity();
        set_ramp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdy",  64'(rdy0), 64'd0);
        check_eq("rst_dout", 64'(dout0), 64'd0);
        check_eq("rst_vld",  64'(dv0), 64'd0);
        check_eq("rst_end",  64'(de0), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Identity, P=0 S=1
        base = q0.size();
        send_frame(0, 1'b0, 16, w);
        check_eq("ident_idle_bubble", 64'(w), 64'd1);
        repeat (8) @(posedge clk); #1;
        expq.delete();
        for (int p = 0; p < 16; p++) expq.push_back({px1[p][15:0], px0[p][15:0]});
        check_out(0, base, "ident");
        check_eq("ident_latency", 64'(first_out0 - first_acc0), 64'd3);

        // Padding, P=1 S=1, pointwise bias 5
        pb = '{5, 5};
        base = q1.size();
        acc0 = acc_cnt[1];
        send_frame(1, 1'b0, 16, w);
        check_eq("pad_rdy_wait", 64'(w), 64'd8);
        repeat (12) @(posedge clk); #1;
        check_eq("pad_accepts", 64'(acc_cnt[1] - acc0), 64'd16);
        expq.delete();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (r == 0 || r == 5 || c == 0 || c == 5)
                    expq.push_back({16'd5, 16'd5});
                else
                    expq.push_back({16'(px1[(r-1)*4+(c-1)] + 5), 16'(px0[(r-1)*4+(c-1)] + 5)});
            end
        end
        check_out(1, base, "pad");

        // Stride, P=0 S=2
        pb = '{0, 0};
        base = q2.size();
        acc0 = acc_cnt[2];
        send_frame(2, 1'b0, 16, w);
        repeat (8) @(posedge clk); #1;
        check_eq("stride_accepts", 64'(acc_cnt[2] - acc0), 64'd16);
        expq.delete();
        expq.push_back({px1[0][15:0],  px0[0][15:0]});
        expq.push_back({px1[2][15:0],  px0[2][15:0]});
        expq.push_back({px1[8][15:0],  px0[8][15:0]});
        expq.push_back({px1[10][15:0], px0[10][15:0]});
        check_out(2, base, "stride");

        // Channel mix with biases and shifts, gapless then gapped
        dw = '{3, -1}; db = '{4, -2}; ds = '{0, 0};
        pw = '{1, 2, 3, 4}; pb = '{0, 0}; ps = '{0, 1};
        expq.delete();
        for (int p = 0; p < 16; p++) expq.push_back(model_px(px0[p], px1[p]));
        base = q0.size();
        send_frame(0, 1'b0, 16, w);
        repeat (8) @(posedge clk); #1;
        check_out(0, base, "mix");
        base = q0.size();
        send_frame(0, 1'b1, 16, w);
        repeat (8) @(posedge clk); #1;
        check_out(0, base, "mixgap");

        // Saturation and floor shift
        dw = '{2, 1}; db = '{0, 0}; ds = '{0, 1};
        pw = '{1, 0, 0, 1}; pb = '{0, 0}; ps = '{0, 0};
        for (int p = 0; p < 16; p++) begin
            px0[p] = 0;
            px1[p] = -3;
        end
        px0[0] = 32767;
        px0[1] = -32768;
        expq.delete();
        for (int p = 0; p < 16; p++) begin
`ifdef DWCONV_K1S_RELU_EN
            e0 = (p == 0) ? 16'h7FFF : 16'h0000;
            e1 = 16'h0000;
`else
            e0 = (p == 0) ? 16'h7FFF : (p == 1) ? 16'h8000 : 16'h0000;
            e1 = 16'hFFFE;
`endif
            expq.push_back({e1, e0});
        end
        base = q0.size();
        send_frame(0, 1'b0, 16, w);
        repeat (8) @(posedge clk); #1;
        check_out(0, base, "arith");

        // Reset after 5 pixels, then a clean frame
        set_identity();
        set_ramp();
        send_frame(0, 1'b0, 5, w);
        rst_n = 1'b0;
        base = q0.size();
        repeat (2) begin
            @(negedge clk);
            check_eq("midrst_vld",  64'(dv0), 64'd0);
            check_eq("midrst_dout", 64'(dout0), 64'd0);
            check_eq("midrst_rdy",  64'(rdy0), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        check_eq("midrst_no_stale", 64'(q0.size() - base), 64'd0);
        expq.delete();
        for (int p = 0; p < 16; p++) expq.push_back({px1[p][15:0], px0[p][15:0]});
        base = q0.size();
        send_frame(0, 1'b0, 16, w);
        repeat (8) @(posedge clk); #1;
        check_out(0, base, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dwconv_k1s.md
# dwconv_k1s

Depthwise-separable 1x1 convolution with zero padding and stride, for the streaming NN pipeline. Accepts one pixel (all input channels in parallel) per handshake in raster order. Inserts padding positions itself, decimates by stride, and runs a per-channel depthwise scale followed by a pointwise channel mix. Emits OUTPUT_SIZE×OUTPUT_SIZE pixels per frame with an end flag. It replaces separate dconv/pconv wrappers wherever padding or stride is non-trivial.

## Interface
- N, 16, signed data/weight width
- INPUT_CHANNEL, 3, input channels
- INPUT_SIZE, 6, input frame side length
- OUTPUT_CHANNEL, 3, output channels
- STRIDE, 1, spatial stride (≥1)
- PADDING, 0, zero border width (≥0); OUTPUT_SIZE = (INPUT_SIZE+2*PADDING-1)/STRIDE+1 is a derived localparam
- clk  in  1  clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- input_vld  in  1  input pixel valid
- input_rdy  out  1  block accepts pixel this cycle
- input_din  in  INPUT_CHANNEL*N  pixel, channel i at [i*N +: N]
- dconv_weight_din  in  INPUT_CHANNEL*N  depthwise weight per channel
- pconv_weight_din  in  INPUT_CHANNEL*OUTPUT_CHANNEL*N  weight (o,i) at index o*INPUT_CHANNEL+i
- dconv_bias_din  in  INPUT_CHANNEL*32  signed bias per channel
- pconv_bias_din  in  OUTPUT_CHANNEL*32  signed bias per output channel
- dconv_shift_din  in  INPUT_CHANNEL*5  right shift per channel
- pconv_shift_din  in  OUTPUT_CHANNEL*5  right shift per output channel
- conv_dout  out  OUTPUT_CHANNEL*N  output pixel
- conv_dout_vld  out  1  output valid
- conv_dout_end  out  1  high with the last output pixel of a frame

## Operation
- Walker FSM covers the padded grid (INPUT_SIZE+2*PADDING)², row r, column c.
- IDLE: input_rdy=0. On input_vld=1, go to RUN at (0,0).
- RUN, pad position: input_rdy=0. Advances one position per cycle.
- RUN, real position: input_rdy=1. Advances only on input_vld&input_rdy.
- Advancing from the last position returns to IDLE. This costs one bubble cycle per frame.
- On-stride positions (r%STRIDE==0 and c%STRIDE==0) enter the datapath. Pad positions inject a zero pixel. Off-stride real pixels are consumed and dropped.
- Producer must hold input_din/input_vld stable until accepted.
- Depthwise, per channel i: y_i = sat_N((x_i*w_i + b_i) >>> s_i). Product is 2N bits, sign-extended to 32 before the add. Shift is arithmetic (floor).
- Pointwise, per output o: z_o = sat_N((Σ_i y_i*w_oi + b_o) >>> s_o). Accumulator width is max(32, 2N+clog2(INPUT_CHANNEL)+1).
- sat_N clamps to [-2^(N-1), 2^(N-1)-1].
- Weights, biases and shifts are static during a frame. Changing them mid-frame gives undefined values but no protocol violation.

## Timing
- Pipeline has 3 register stages and no output backpressure. Let edge k be the edge that accepts a real pixel or generates a pad position.
  - Stage 1: depthwise result, registered at edge k.
  - Stage 2: pointwise products, registered at edge k+1.
  - Stage 3: sum/shift/saturate, registered at edge k+2. conv_dout and conv_dout_vld are visible after edge k+2.
- conv_dout_end asserts for exactly one cycle, with the OUTPUT_SIZE²-th output.
- Back-to-back frames: a new frame's first pixel may be accepted on the cycle after the IDLE bubble. The pipeline drains independently.
- Reset values: input_rdy=0, conv_dout=0, conv_dout_vld=0, conv_dout_end=0. FSM goes to IDLE, counters to 0, pipeline valids to 0.
- Reset mid-frame discards in-flight data. No stale valid appears after release.
- STRIDE > padded size yields OUTPUT_SIZE=1, i.e. only (0,0).

## Configuration
- DWCONV_K1S_RELU_EN defined: apply ReLU (negatives → 0) to y_i after depthwise saturation and to z_o after pointwise saturation. ReLU is zero-latency and the pipeline depth is unchanged.
- Not defined: outputs are signed, with no clamping beyond sat_N.

## Structure
- Shared package nn_pkg holds:
  - the saturation function;
  - ACC_W computation;
  - bias width (32) and shift width (5) constants.
- Sub-module pad_stride_walker holds the FSM, r/c counters, input_rdy, pad/on-stride/last flags and frame-end tagging. Datapath stages stay in dwconv_k1s.

## Test plan
All cases use N=16, IC=OC=2, INPUT_SIZE=4.
- Identity, P=0, S=1. dw weights=1, biases 0, shifts 0, pw weights identity. Input ramp 1..16 → 16 outputs equal to inputs. Latency 3 edges. End flag on output 16 only.
- Padding, P=1, S=1. pconv bias=5, other biases 0. Expect 36 outputs, with all 20 border outputs =5. input_rdy low for the first 7 RUN cycles, and never high on a pad position.
- Stride, P=0, S=2. Expect 4 outputs from pixels (0,0),(0,2),(2,0),(2,2). All 16 inputs are accepted.
- Arithmetic:
  - x=0x7FFF, w=2, shift 0 → 0x7FFF.
  - x=-0x8000, w=2 → 0x8000.
  - x*w+b=-3, shift 1 → -2.
  - With RELU_EN, the negative cases → 0.
- Gapped input: input_vld toggles pseudo-randomly → outputs and count match the gapless run exactly.
- Reset mid-frame (after 5 pixels), then a full frame → no output during or after reset until the new frame. New frame outputs are correct.
